// File: rtl/bcd_convert_arbiter_if.sv
// Requester-side bus of the shared BCD converter arbiter: level requests with
// flattened operands in, one-hot ack with result and status flags out.
interface bcd_convert_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 14
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] bin_flat;
  logic [NREQ-1:0]       ack;
  logic [15:0]           result;
  logic                  sat;
  logic                  err;

  modport master (output req, bin_flat, input ack, result, sat, err);
  modport slave  (input req, bin_flat, output ack, result, sat, err);
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one serial binary-to-BCD converter among NREQ
// requesters: clamps the operand, pulses start, waits for done or timeout, acks.
module bcd_convert_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 14,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  bcd_convert_arbiter_if.slave bus,
  output logic               busy,
  output logic               conv_start,
  output logic [WIDTH-1:0]   conv_bin,
  input  logic               conv_done,
  input  logic [15:0]        conv_bcd
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  // Reduce a sum of two in-range indices back into 0..NREQ-1.
  function automatic logic [IW-1:0] wrap(input logic [IW:0] v);
    logic [IW:0] r;
    r = (v >= (IW+1)'(NREQ)) ? v - (IW+1)'(NREQ) : v;
    return r[IW-1:0];
  endfunction

  state_t            state_reg;
  logic [IW-1:0]     rr_ptr_reg;
  logic [IW-1:0]     grant_reg;
  logic [TW-1:0]     timer_reg;
  logic              sat_pend_reg;
  logic [NREQ-1:0]   ack_reg;
  logic [15:0]       result_reg;
  logic              sat_reg;
  logic              err_reg;
  logic              busy_reg;
  logic              conv_start_reg;
  logic [WIDTH-1:0]  conv_bin_reg;

  logic [WIDTH-1:0]  bin_arr [NREQ];
  logic [NREQ-1:0]   req_rot;
  logic [IW-1:0]     grant_off;
  logic              grant_any;
  logic [IW-1:0]     grant_idx;
  logic [WIDTH-1:0]  grant_operand;
  logic              grant_clamp;

  // req_rot[k] is the request k positions after the round-robin pointer.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign bin_arr[gi] = bus.bin_flat[gi*WIDTH +: WIDTH];
      assign req_rot[gi] = bus.req[wrap({1'b0, rr_ptr_reg} + (IW+1)'(gi))];
    end
  endgenerate

  always_comb begin
    grant_off = '0;
    grant_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_off = IW'(i);
        grant_any = 1'b1;
      end
    end
  end

  assign grant_idx     = wrap({1'b0, rr_ptr_reg} + {1'b0, grant_off});
  assign grant_operand = bin_arr[grant_idx];
  assign grant_clamp   = 32'(grant_operand) > 32'd9999;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      grant_reg      <= '0;
      timer_reg      <= '0;
      sat_pend_reg   <= 1'b0;
      ack_reg        <= '0;
      result_reg     <= '0;
      sat_reg        <= 1'b0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      conv_start_reg <= 1'b0;
      conv_bin_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            grant_reg      <= grant_idx;
            conv_bin_reg   <= grant_clamp ? WIDTH'(9999) : grant_operand;
            sat_pend_reg   <= grant_clamp;
            rr_ptr_reg     <= wrap({1'b0, grant_idx} + (IW+1)'(1));
            conv_start_reg <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          conv_start_reg <= 1'b0;
          timer_reg      <= '0;
          state_reg      <= WAIT;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (conv_done) begin
            result_reg <= conv_bcd;
            sat_reg    <= sat_pend_reg;
            err_reg    <= 1'b0;
            ack_reg    <= NREQ'(1) << grant_reg;
            state_reg  <= DELIVER;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            result_reg <= '0;
            sat_reg    <= sat_pend_reg;
            err_reg    <= 1'b1;
            ack_reg    <= NREQ'(1) << grant_reg;
            state_reg  <= DELIVER;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        DELIVER: begin
          ack_reg   <= '0;
          sat_reg   <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ack     = ack_reg;
  assign bus.result  = result_reg;
  assign bus.sat     = sat_reg;
  assign bus.err     = err_reg;
  assign busy        = busy_reg;
  assign conv_start  = conv_start_reg;
  assign conv_bin    = conv_bin_reg;
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Scoreboard bench for bcd_convert_arbiter with a behavioural serial converter
// whose completion delay is set per operation (0 = never completes).
module tb_bcd_convert_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 14;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             busy;
  logic             conv_start;
  logic [WIDTH-1:0] conv_bin;
  logic             conv_done;
  logic [15:0]      conv_bcd;

  bcd_convert_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  bcd_convert_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .conv_start (conv_start),
    .conv_bin   (conv_bin),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd)
  );

  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        sat;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ack_seen    = 0;
  int start_count = 0;
  int start_cyc   = 0;
  int conv_delay  = 1;
  int d_lat       = 0;
  int cnt         = 0;
  logic             pend = 1'b0;
  logic [WIDTH-1:0] lat_bin = '0;
  logic [NREQ-1:0]  auto_drop = '1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input logic [WIDTH-1:0] v);
    int n = int'(v);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic set_op(input int i, input int v);
    bus.bin_flat[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic push(input int idx, input logic [15:0] res, input logic sat, input logic err);
    exp_t e;
    e.idx = idx; e.res = res; e.sat = sat; e.err = err;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target = ack_seen + n;
    int k = 0;
    while (ack_seen < target && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (ack_seen < target) check("ack_timeout", 32'(ack_seen), 32'(target));
  endtask

  task automatic wait_start(input int s0, input int budget);
    int k = 0;
    while (start_count == s0 && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (start_count == s0) check("start_timeout", 32'(start_count), 32'(s0 + 1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"},        32'(bus.ack),    32'd0);
    check({tag, "_result"},     32'(bus.result), 32'd0);
    check({tag, "_sat"},        32'(bus.sat),    32'd0);
    check({tag, "_err"},        32'(bus.err),    32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_conv_start"}, 32'(conv_start), 32'd0);
    check({tag, "_conv_bin"},   32'(conv_bin),   32'd0);
  endtask

  // Monitor/scoreboard and converter model, both sampling 1 ns after the edge.
  initial begin
    conv_done = 1'b0;
    conv_bcd  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        pend      = 1'b0;
        conv_done = 1'b0;
      end else begin
        if (bus.ack != '0) begin
          exp_t e;
          ack_seen++;
          $display("ack=%b result=%h sat=%b err=%b cyc=%0d", bus.ack, bus.result, bus.sat, bus.err, cyc);
          if (sb.size() == 0) begin
            check("spurious_ack", 32'(bus.ack), 32'd0);
          end else begin
            e = sb.pop_front();
            check("ack",     32'(bus.ack),    32'd1 << e.idx);
            check("result",  32'(bus.result), 32'(e.res));
            check("sat",     32'(bus.sat),    32'(e.sat));
            check("err",     32'(bus.err),    32'(e.err));
            check("latency", 32'(cyc - start_cyc), e.err ? 32'(TIMEOUT + 1) : 32'(d_lat + 1));
          end
          bus.req = bus.req & ~(bus.ack & auto_drop);
        end else if (bus.sat || bus.err) begin
          check("flags_without_ack", {30'd0, bus.sat, bus.err}, 32'd0);
        end

        conv_done = 1'b0;
        if (conv_start) begin
          start_count++;
          start_cyc = cyc;
          lat_bin   = conv_bin;
          d_lat     = conv_delay;
          cnt       = conv_delay;
          pend      = (conv_delay > 0);
        end else if (pend) begin
          cnt--;
          if (cnt == 0) begin
            conv_done = 1'b1;
            conv_bcd  = to_bcd(lat_bin);
            pend      = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int s0;
    bus.req      = '0;
    bus.bin_flat = '0;
    reset        = 1'b0;
    cycles(3);
    check_idle("por");
    reset = 1'b1;
    cycles(1);

    // All four requesting continuously: grants rotate 0,1,2,3,0.
    set_op(0, 7); set_op(1, 9999); set_op(2, 10000); set_op(3, 4321);
    conv_delay = 1;
    auto_drop  = '0;
    push(0, 16'h0007, 1'b0, 1'b0);
    push(1, 16'h9999, 1'b0, 1'b0);
    push(2, 16'h9999, 1'b1, 1'b0);
    push(3, 16'h4321, 1'b0, 1'b0);
    push(0, 16'h0007, 1'b0, 1'b0);
    bus.req = 4'b1111;
    wait_acks(5, 200);
    bus.req   = '0;
    auto_drop = '1;
    cycles(3);
    check("rr_busy_after", 32'(busy), 32'd0);

    // Single request with a slow converter: exactly one start pulse.
    s0 = start_count;
    set_op(1, 1234);
    conv_delay = 20;
    push(1, 16'h1234, 1'b0, 1'b0);
    bus.req = 4'b0010;
    wait_acks(1, 200);
    cycles(3);
    check("single_starts", 32'(start_count - s0), 32'd1);

    // Full-scale operand is clamped to 9999.
    set_op(2, 16383);
    conv_delay = 3;
    push(2, 16'h9999, 1'b1, 1'b0);
    bus.req = 4'b0100;
    wait_acks(1, 200);
    check("clamp_conv_bin", 32'(lat_bin), 32'd9999);
    cycles(2);

    // Converter never answers: error ack after the timeout, then normal service.
    set_op(3, 500);
    conv_delay = 0;
    push(3, 16'h0000, 1'b0, 1'b1);
    bus.req = 4'b1000;
    wait_acks(1, 300);
    cycles(2);
    set_op(0, 55);
    conv_delay = 2;
    push(0, 16'h0055, 1'b0, 1'b0);
    bus.req = 4'b0001;
    wait_acks(1, 200);
    cycles(2);

    // Reset in the middle of WAIT aborts the op and clears the pointer.
    s0 = start_count;
    set_op(1, 100);
    conv_delay = 50;
    bus.req = 4'b0010;
    wait_start(s0, 50);
    cycles(5);
    reset = 1'b0;
    #1;
    check_idle("midwait_rst");
    bus.req = '0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
    set_op(1, 11); set_op(3, 33);
    conv_delay = 2;
    push(1, 16'h0011, 1'b0, 1'b0);
    push(3, 16'h0033, 1'b0, 1'b0);
    bus.req = 4'b1010;
    wait_acks(2, 200);
    cycles(2);

    // Request withdrawn and operand changed while the op is in flight.
    s0 = start_count;
    set_op(0, 300);
    conv_delay = 15;
    push(0, 16'h0300, 1'b0, 1'b0);
    bus.req = 4'b0001;
    wait_start(s0, 50);
    cycles(4);
    bus.req[0] = 1'b0;
    set_op(0, 500);
    wait_acks(1, 200);
    cycles(5);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
